// File: rtl/rw_step_pkg.sv
// Shared types and default sizing for the round-robin step arbiter.
package rw_step_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_IN_W    = 1;
  localparam int DEF_OUT_W   = 1;
  localparam int DEF_ID_W    = $clog2(DEF_NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2,
    HALT  = 2'd3
  } step_state_t;

  // Response record at the default sizing
  typedef struct packed {
    logic [DEF_ID_W-1:0]  id;
    logic [DEF_OUT_W-1:0] data;
    logic                 last;
  } rsp_t;

endpackage

// File: rtl/rw_step_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after ptr, wrapping.
module rw_rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic            any,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx
);

  int unsigned c;

  always_comb begin
    any   = 1'b0;
    grant = '0;
    idx   = '0;
    c     = 0;
    // Offsets 1..N visit every requester once, ending on ptr itself
    for (int unsigned i = 1; i <= N; i++) begin
      c = (32'(ptr) + i) % N;
      if (!any && req[c[ID_W-1:0]]) begin
        any                  = 1'b1;
        grant[c[ID_W-1:0]]   = 1'b1;
        idx                  = c[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rw_step_arbiter.sv
// Shares one single-step reactive device among NUM_REQ requesters, one step per grant.
module rw_step_arbiter
  import rw_step_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [IN_W-1:0]         dev_in,
  input  logic [OUT_W-1:0]        dev_out,
  input  logic                    dev_cont,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [OUT_W-1:0]        rsp_data,
  output logic                    rsp_last,
  input  logic                    rsp_ready,
  output logic                    halted
);

  step_state_t         state;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     grant_q;
  logic                pick_any;
  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]     pick_idx;
  logic [IN_W-1:0]     sel_data;

  rw_rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .any   (pick_any),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign sel_data = req_data[pick_idx*IN_W +: IN_W];

  // Grant is offered only in IDLE and suppressed while reset is held
  assign req_ready = (state == IDLE && rst) ? pick_grant : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= ID_W'(NUM_REQ - 1);
      grant_q   <= '0;
      dev_in    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
      halted    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            dev_in  <= sel_data;
            grant_q <= pick_idx;
            ptr     <= pick_idx;
            state   <= DRIVE;
          end
        end
        DRIVE: begin
          rsp_data  <= dev_out;
          rsp_last  <= ~dev_cont;
          rsp_id    <= grant_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_last) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              state  <= IDLE;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rw_step_arbiter.sv
// Directed bench for rw_step_arbiter with an inverter device model.
module tb_rw_step_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_data;
  logic [N-1:0] req_ready;
  logic [0:0]   dev_in;
  logic [0:0]   dev_out;
  logic         dev_cont;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [0:0]   rsp_data;
  logic         rsp_last;
  logic         rsp_ready;
  logic         halted;
  logic         cont_force;

  int passed;
  int total;

  rw_step_arbiter #(
    .NUM_REQ (N),
    .IN_W    (1),
    .OUT_W   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .dev_in    (dev_in),
    .dev_out   (dev_out),
    .dev_cont  (dev_cont),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .rsp_ready (rsp_ready),
    .halted    (halted)
  );

  assign dev_out  = ~dev_in;
  assign dev_cont = cont_force;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b0; req_valid = 4'b1111; req_data = '0; rsp_ready = 1'b0; cont_force = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    total++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b expected 0000", req_ready); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else passed++;
    total++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); else passed++;
    total++; if (rsp_data !== 1'b0 || rsp_last !== 1'b0) $display("FAIL reset_rsp_fields: got data=%b last=%b expected 0 0", rsp_data, rsp_last); else passed++;
    total++; if (dev_in !== 1'b0 || halted !== 1'b0) $display("FAIL reset_dev_halted: got dev_in=%b halted=%b expected 0 0", dev_in, halted); else passed++;
    req_valid = '0;
    rst = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = 4'b0100; req_data = 4'b0100; rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0100) $display("FAIL single_grant: got %b expected 0100", req_ready); else passed++;
    @(negedge clk);
    req_valid = '0;
    #1;
    total++; if (req_ready !== 4'b0000) $display("FAIL single_ready_pulse: got %b expected 0000", req_ready); else passed++;
    total++; if (dev_in !== 1'b1) $display("FAIL single_dev_in: got %b expected 1", dev_in); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL single_early_valid: got %b expected 0", rsp_valid); else passed++;
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b1) $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); else passed++;
    total++; if (rsp_id !== 2'd2) $display("FAIL single_rsp_id: got %0d expected 2", rsp_id); else passed++;
    total++; if (rsp_data !== 1'b0 || rsp_last !== 1'b0) $display("FAIL single_rsp_fields: got data=%b last=%b expected 0 0", rsp_data, rsp_last); else passed++;
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) $display("FAIL single_back_idle: got valid=%b ready=%b expected 0 0001", rsp_valid, req_ready); else passed++;
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_grant [5];
    logic [1:0]   exp_id    [5];
    logic [0:0]   exp_data  [5];
    int           g_cycle   [5];
    int           ng;
    int           nr;
    exp_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_data  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    ng = 0; nr = 0;
    @(negedge clk);
    rst = 1'b0; #1; rst = 1'b1;
    req_valid = 4'b1111; req_data = 4'b1010; rsp_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (req_ready !== 4'b0000) begin
        if (ng < 5) begin
          total++; if (req_ready !== exp_grant[ng]) $display("FAIL rr_grant%0d: got %b expected %b", ng, req_ready, exp_grant[ng]); else passed++;
          g_cycle[ng] = i;
          if (ng > 0) begin
            total++; if (g_cycle[ng] - g_cycle[ng-1] !== 3) $display("FAIL rr_period%0d: got %0d expected 3", ng, g_cycle[ng] - g_cycle[ng-1]); else passed++;
          end
        end
        ng++;
      end
      if (rsp_valid === 1'b1) begin
        if (nr < 5) begin
          total++; if (rsp_id !== exp_id[nr] || rsp_data !== exp_data[nr]) $display("FAIL rr_rsp%0d: got id=%0d data=%b expected id=%0d data=%b", nr, rsp_id, rsp_data, exp_id[nr], exp_data[nr]); else passed++;
        end
        nr++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    total++; if (ng !== 5 || nr !== 5) $display("FAIL rr_counts: got grants=%0d rsps=%0d expected 5 5", ng, nr); else passed++;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req_valid = 4'b0010; req_data = 4'b0000; rsp_ready = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0010) $display("FAIL bp_grant: got %b expected 0010", req_ready); else passed++;
    @(negedge clk);
    req_valid = 4'b1111;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 1'b1) $display("FAIL bp_hold%0d: got valid=%b id=%0d data=%b expected 1 1 1", i, rsp_valid, rsp_id, rsp_data); else passed++;
      total++; if (req_ready !== 4'b0000) $display("FAIL bp_no_ready%0d: got %b expected 0000", i, req_ready); else passed++;
      if (i < 4) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    total++; if (req_ready !== 4'b0100 || rsp_valid !== 1'b0) $display("FAIL bp_release: got ready=%b valid=%b expected 0100 0", req_ready, rsp_valid); else passed++;
    req_valid = '0;
  endtask

  task automatic test_accept_capture();
    @(negedge clk);
    req_valid = 4'b0010; req_data = 4'b0010; rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0010) $display("FAIL cap_grant: got %b expected 0010", req_ready); else passed++;
    @(negedge clk);
    req_valid = '0; req_data = '0;
    #1;
    total++; if (dev_in !== 1'b1) $display("FAIL cap_dev_in: got %b expected 1", dev_in); else passed++;
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 1'b0) $display("FAIL cap_rsp: got valid=%b id=%0d data=%b expected 1 1 0", rsp_valid, rsp_id, rsp_data); else passed++;
    @(negedge clk);
    req_valid = 4'b0001; req_data = 4'b0000;
    #1;
    total++; if (req_ready !== 4'b0001) $display("FAIL drop_offer: got %b expected 0001", req_ready); else passed++;
    #1 req_valid = '0;
    @(negedge clk); #1;
    total++; if (dev_in !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL drop_no_accept: got dev_in=%b valid=%b expected 1 0", dev_in, rsp_valid); else passed++;
    req_valid = 4'b1000;
    #1;
    total++; if (req_ready !== 4'b1000) $display("FAIL drop_still_idle: got %b expected 1000", req_ready); else passed++;
    req_valid = '0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    req_valid = 4'b1000; req_data = 4'b1000; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || dev_in !== 1'b1) $display("FAIL ar_pre: got valid=%b id=%0d dev_in=%b expected 1 3 1", rsp_valid, rsp_id, dev_in); else passed++;
    #1 rst = 1'b0;
    req_valid = 4'b1111;
    #1;
    total++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || dev_in !== 1'b0 || halted !== 1'b0) $display("FAIL ar_clear: got valid=%b id=%0d dev_in=%b halted=%b expected 0 0 0 0", rsp_valid, rsp_id, dev_in, halted); else passed++;
    total++; if (req_ready !== 4'b0000) $display("FAIL ar_ready_in_reset: got %b expected 0000", req_ready); else passed++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0001) $display("FAIL ar_first_winner: got %b expected 0001", req_ready); else passed++;
    req_valid = '0; rsp_ready = 1'b1;
  endtask

  task automatic test_halt();
    @(negedge clk);
    req_valid = 4'b0001; req_data = 4'b0000; rsp_ready = 1'b1; cont_force = 1'b1;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b1 || rsp_last !== 1'b0) $display("FAIL halt_step1: got valid=%b last=%b expected 1 0", rsp_valid, rsp_last); else passed++;
    @(negedge clk);
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0; cont_force = 1'b0;
    @(negedge clk); #1;
    cont_force = 1'b1;
    total++; if (rsp_valid !== 1'b1 || rsp_last !== 1'b1 || rsp_id !== 2'd1 || halted !== 1'b0) $display("FAIL halt_step2: got valid=%b last=%b id=%0d halted=%b expected 1 1 1 0", rsp_valid, rsp_last, rsp_id, halted); else passed++;
    @(negedge clk); #1;
    total++; if (halted !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL halt_enter: got halted=%b valid=%b expected 1 0", halted, rsp_valid); else passed++;
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      cont_force = i[0];
      @(negedge clk); #1;
      total++; if (req_ready !== 4'b0000 || halted !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL halt_hold%0d: got ready=%b halted=%b valid=%b expected 0000 1 0", i, req_ready, halted, rsp_valid); else passed++;
    end
    req_valid = '0; cont_force = 1'b1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_accept_capture();
    test_async_reset();
    test_halt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rw_step_arbiter.md
Name: rw_step_arbiter

Overview:
- Round-robin scheduler that shares one single-step reactive datapath among NUM_REQ requesters.
- The datapath is a compiled reactive device with `__in0`, `__out0` and `__continue`, and is combinational per step.
- Per grant, the block drives exactly one step, captures the device output and continue flag, and returns them to the granted requester.
- Once the device reports `__continue`=0, the block stops issuing steps and stays halted.

Parameters:
- NUM_REQ, 4: number of requesters (2..16).
- IN_W, 1: width of the device `__in0`.
- OUT_W, 1: width of the device `__out0`.
- ID_W, $clog2(NUM_REQ): requester index width (derived).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester step request.
- req_data  input  NUM_REQ*IN_W  per-requester step input; slice i belongs to requester i.
- req_ready  output  NUM_REQ  one-hot accept pulse.
- dev_in  output  IN_W  registered drive to device `__in0`.
- dev_out  input  OUT_W  device `__out0`.
- dev_cont  input  1  device `__continue`.
- rsp_valid  output  1  response available.
- rsp_id  output  ID_W  requester owning the response.
- rsp_data  output  OUT_W  captured device output.
- rsp_last  output  1  device reported termination on this step (~dev_cont).
- rsp_ready  input  1  response consumer ready.
- halted  output  1  sticky; device finished.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; dev_in=0; rsp_valid=0; rsp_id=0; rsp_data=0; rsp_last=0; halted=0; req_ready=0.
  - Priority pointer = NUM_REQ-1, so requester 0 wins first.
- States: IDLE, DRIVE, RESP, HALT.
- IDLE:
  - If any req_valid, choose the first set bit searching from ptr+1 upward with wrap.
  - Combinationally assert req_ready[g] this cycle. Accept = req_valid[g] & req_ready[g].
  - Register dev_in <= req_data[g]; grant_q <= g; ptr <= g; go to DRIVE.
  - With no request: stay, dev_in holds its last value.
- DRIVE (one cycle): dev_in stable. At the clock edge capture rsp_data <= dev_out, rsp_last <= ~dev_cont, rsp_id <= grant_q; rsp_valid <= 1; go to RESP.
- RESP:
  - Hold rsp_valid and rsp_* stable until rsp_valid & rsp_ready.
  - On handshake: rsp_valid <= 0; if rsp_last then halted <= 1 and go to HALT, else go to IDLE.
  - req_ready=0 throughout.
- HALT: absorbing until reset. req_ready=0, rsp_valid=0, dev_in holds, halted=1.
- Latency and throughput:
  - Accept edge to rsp_valid high: 2 cycles.
  - Minimum step period: 3 cycles (IDLE→DRIVE→RESP→IDLE) when rsp_ready is held high.
- req_ready is asserted only in IDLE and at most one bit per cycle. Requesters must hold req_data stable while req_valid is high.
- Fairness:
  - A continuously requesting source waits at most NUM_REQ-1 grants.
  - Pointer wrap: after granting NUM_REQ-1, the search restarts at 0.
- Simultaneous events:
  - A req_valid drop in the same cycle as req_ready means no accept; the arbiter re-evaluates next cycle and stays in IDLE.
  - dev_cont sampled 0 during DRIVE still delivers that response (rsp_last=1) before halting.
- Reset mid-operation (any state): the pending response is discarded, the pointer returns to NUM_REQ-1, and halted clears.
- dev_out and dev_cont are sampled only in DRIVE. Glitches in other states are ignored.

Decomposition:
- Package `rw_step_pkg`:
  - State enum `step_state_t` {IDLE, DRIVE, RESP, HALT}.
  - Default parameter constants and a `rsp_t` struct {id, data, last}.
- Sub-module `rw_rr_pick`:
  - Combinational round-robin selector.
  - Inputs: request vector, pointer. Outputs: any, one-hot grant, binary index.
  - Instantiated once.
- Top holds the FSM and registers.

Test Plan:
Device model for all scenarios: inverter, dev_out = ~dev_in, dev_cont = 1, NUM_REQ=4, IN_W=OUT_W=1.
1. Reset then single requester 2 with req_data=1, rsp_ready=1 → req_ready=4'b0100 for one cycle; 2 cycles later rsp_valid=1, rsp_id=2, rsp_data=0, rsp_last=0; state returns to IDLE.
2. All four req_valid held high, rsp_ready=1 → grant order 0,1,2,3,0 (pointer wraps); one grant every 3 cycles; no requester granted twice before the others.
3. rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid, rsp_id and rsp_data stay constant; no new req_ready pulse until handshake.
4. Device forced dev_cont=0 on the second step → second response has rsp_last=1; after its handshake halted=1; further req_valid see req_ready=0 indefinitely.
5. rst pulsed low while in RESP → all outputs return to reset values asynchronously; after release, requester 0 wins first.
6. req_valid[1] high for one cycle coincident with req_ready[1], then req_data changed → captured dev_in equals the value presented at accept.
